inst_mem_pingpong: RTL and testbench

//  Parametrised double-banked instruction memory with explicit load/run control. Replaces the fixed

---
 rtl/inst_mem_pingpong.sv | 124 ++++++++++++
 tb/tb_inst_mem_pingpong.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pingpong.sv
// inst_mem_pingpong: double-banked instruction memory, one bank loads while the other issues
module inst_mem_pingpong #(
    parameter int INST_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_in_v,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic                  load_last,
    output logic                  load_full,
    output logic                  load_ovf,
    input  logic                  run_start,
    input  logic [LOOP_WIDTH-1:0] loop_cnt,
    input  logic                  inst_out_rdy,
    output logic                  inst_out_v,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  inst_out_last,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [INST_WIDTH-1:0]      mem [0:2*DEPTH-1];
    state_t                     state_q;
    logic                       wr_bank_q, rd_bank_q;
    logic [1:0]                 bank_valid_q, bank_valid_d;
    logic [ADDR_WIDTH-1:0]      wr_cnt_q, pc_q;
    logic [1:0][ADDR_WIDTH:0]   len_q;
    logic [LOOP_WIDTH-1:0]      iter_q, loop_q;
    logic [INST_WIDTH-1:0]      inst_out_q;
    logic                       inst_out_v_q, inst_out_last_q, load_ovf_q;
    logic                       wr_acc, wr_close, adv, issue, pc_wrap, final_issue, rel, start;

    assign wr_acc      = inst_in_v & ~bank_valid_q[wr_bank_q];
    assign wr_close    = wr_acc & (load_last | (&wr_cnt_q));
    assign adv         = ~inst_out_v_q | inst_out_rdy;
    assign issue       = (state_q == RUN) & adv;
    assign pc_wrap     = {1'b0, pc_q} == len_q[rd_bank_q] - LEN_ONE;
    assign final_issue = issue & pc_wrap & (iter_q == loop_q);
    assign rel         = (state_q == DRAIN) & inst_out_v_q & inst_out_rdy & inst_out_last_q;
    assign start       = (state_q == IDLE) & run_start & bank_valid_q[rd_bank_q];

    assign load_full     = &bank_valid_q;
    assign load_ovf      = load_ovf_q;
    assign inst_out_v    = inst_out_v_q;
    assign inst_out      = inst_out_q;
    assign inst_out_last = inst_out_last_q;
    assign busy          = state_q != IDLE;

    // Bank ownership: release of the read bank and close of the write bank can coincide
    always_comb begin
        bank_valid_d = bank_valid_q;
        if (rel) bank_valid_d[rd_bank_q] = 1'b0;
        if (wr_close) bank_valid_d[wr_bank_q] = 1'b1;
    end

    // Load side: write pointer, bank length capture and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            len_q        <= '0;
            bank_valid_q <= '0;
            load_ovf_q   <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_close ? '0 : wr_acc ? wr_cnt_q + ADDR_WIDTH'(1) : wr_cnt_q;
            wr_bank_q    <= wr_close ? ~wr_bank_q : wr_bank_q;
            if (wr_close) len_q[wr_bank_q] <= {1'b0, wr_cnt_q} + LEN_ONE;
            bank_valid_q <= bank_valid_d;
            load_ovf_q   <= wr_acc & ~load_last & (&wr_cnt_q);
        end
    end

    // Storage array, left uninitialised so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_bank_q, wr_cnt_q}] <= inst_in;
    end

    // Registered read port doubles as the output register; it only moves on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inst_out_q <= '0;
        else if (issue) inst_out_q <= mem[{rd_bank_q, pc_q}];
    end

    // Run FSM with program counter, iteration count and registered valid/last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_bank_q       <= 1'b0;
            pc_q            <= '0;
            iter_q          <= '0;
            loop_q          <= '0;
            inst_out_v_q    <= 1'b0;
            inst_out_last_q <= 1'b0;
        end else begin
            if (adv) begin
                inst_out_v_q    <= issue;
                inst_out_last_q <= final_issue;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    pc_q    <= '0;
                    iter_q  <= '0;
                    loop_q  <= loop_cnt;
                end
                RUN: if (adv) begin
                    pc_q    <= pc_wrap ? '0 : pc_q + ADDR_WIDTH'(1);
                    iter_q  <= pc_wrap ? iter_q + LOOP_WIDTH'(1) : iter_q;
                    state_q <= final_issue ? DRAIN : RUN;
                end
                DRAIN: if (rel) begin
                    rd_bank_q <= ~rd_bank_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_pingpong.sv
// tb_inst_mem_pingpong: scoreboard bench for the ping-pong instruction memory
module tb_inst_mem_pingpong;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_in_v = 1'b0;
    logic [63:0] inst_in = '0;
    logic        load_last = 1'b0;
    logic        load_full, load_ovf;
    logic        run_start = 1'b0;
    logic [7:0]  loop_cnt = '0;
    logic        inst_out_rdy = 1'b1;
    logic        inst_out_v, inst_out_last, busy;
    logic [63:0] inst_out;

    int total = 0;
    int bad = 0;
    logic [64:0] sb[$];

    inst_mem_pingpong dut (
        .clk(clk), .rst_n(rst_n), .inst_in_v(inst_in_v), .inst_in(inst_in),
        .load_last(load_last), .load_full(load_full), .load_ovf(load_ovf),
        .run_start(run_start), .loop_cnt(loop_cnt), .inst_out_rdy(inst_out_rdy),
        .inst_out_v(inst_out_v), .inst_out(inst_out), .inst_out_last(inst_out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Every accepted output word is checked against the oldest expected word
    always @(negedge clk) begin
        if (rst_n && inst_out_v && inst_out_rdy) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got data=%h last=%b, required no output", inst_out, inst_out_last);
            end else begin
                logic [64:0] e;
                e = sb.pop_front();
                if ({inst_out_last, inst_out} !== e) begin
                    bad++;
                    $display("FAIL sb_word: got last=%b data=%h, required last=%b data=%h",
                             inst_out_last, inst_out, e[64], e[63:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [63:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            inst_in_v = 1'b1;
            inst_in   = base + 64'(i);
            load_last = with_last && (i == n - 1);
            step();
        end
        inst_in_v = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic push_prog(input logic [63:0] base, input int n, input int loops);
        for (int r = 0; r <= loops; r++)
            for (int i = 0; i < n; i++)
                sb.push_back({(r == loops) && (i == n - 1), base + 64'(i)});
    endtask

    task automatic start_run(input logic [7:0] loops);
        run_start = 1'b1;
        loop_cnt  = loops;
        step();
        run_start = 1'b0;
        loop_cnt  = 8'hEE;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (busy && c < 1000);
        if (busy) c = -1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if ({inst_out_v, inst_out_last, busy, load_full, load_ovf} !== 5'b0 || inst_out !== 64'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b last=%b busy=%b full=%b ovf=%b data=%h, required all 0",
                     inst_out_v, inst_out_last, busy, load_full, load_ovf, inst_out);
        end
        rst_n = 1'b1;
        step();
        start_run(0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_empty_start: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single();
        int c;
        load_prog(64'hA000, 4, 1);
        push_prog(64'hA000, 4, 0);
        start_run(0);
        total++;
        if (busy !== 1'b1 || inst_out_v !== 1'b0) begin
            bad++;
            $display("FAIL t1_T1: got busy=%b v=%b, required busy=1 v=0", busy, inst_out_v);
        end
        step();
        total++;
        if (inst_out_v !== 1'b1 || inst_out !== 64'hA000) begin
            bad++;
            $display("FAIL t1_T2: got v=%b data=%h, required v=1 data=a000", inst_out_v, inst_out);
        end
        wait_idle(c);
        total++;
        if (c != 4 || inst_out_v !== 1'b0) begin
            bad++;
            $display("FAIL t1_finish: got cycles=%0d v=%b, required cycles=4 v=0", c, inst_out_v);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL t1_remaining: got %0d words left, required 0", sb.size());
        end
    endtask

    task automatic test_loop();
        int c;
        load_prog(64'hB000, 3, 1);
        push_prog(64'hB000, 3, 2);
        start_run(2);
        wait_idle(c);
        total++;
        if (c != 10 || sb.size() != 0) begin
            bad++;
            $display("FAIL t2_loop: got cycles=%0d left=%0d, required cycles=10 left=0", c, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int c;
        load_prog(64'hC000, 4, 1);
        push_prog(64'hC000, 4, 0);
        start_run(0);
        step();
        step();
        inst_out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (inst_out_v !== 1'b1 || inst_out !== 64'hC001) begin
                bad++;
                $display("FAIL t3_hold%0d: got v=%b data=%h, required v=1 data=c001", k, inst_out_v, inst_out);
            end
        end
        inst_out_rdy = 1'b1;
        wait_idle(c);
        total++;
        if (c < 0 || sb.size() != 0) begin
            bad++;
            $display("FAIL t3_done: got cycles=%0d left=%0d, required finish with 0 left", c, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int c;
        load_prog(64'hD000, 2, 1);
        push_prog(64'hD000, 2, 3);
        start_run(3);
        load_prog(64'hE000, 3, 1);
        total++;
        if (load_full !== 1'b1) begin
            bad++;
            $display("FAIL t4_full: got load_full=%b, required 1", load_full);
        end
        load_prog(64'hF000, 2, 1);
        wait_idle(c);
        total++;
        if (c < 0 || load_full !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL t4_first_run: got cycles=%0d full=%b left=%0d, required finish full=0 left=0",
                     c, load_full, sb.size());
        end
        push_prog(64'hE000, 3, 0);
        start_run(0);
        wait_idle(c);
        total++;
        if (c != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL t4_second_run: got cycles=%0d left=%0d, required cycles=4 left=0", c, sb.size());
        end
        start_run(0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL t4_no_bank: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_overflow();
        int c;
        int ovf_n = 0;
        int ovf_at = -1;
        for (int i = 0; i < 256; i++) begin
            inst_in_v = 1'b1;
            inst_in   = 64'h5_0000 + 64'(i);
            load_last = 1'b0;
            step();
            if (load_ovf) begin
                ovf_n++;
                ovf_at = i;
            end
        end
        inst_in_v = 1'b0;
        step();
        total++;
        if (ovf_n != 1 || ovf_at != 255 || load_ovf !== 1'b0) begin
            bad++;
            $display("FAIL t5_ovf: got pulses=%0d at=%0d now=%b, required pulses=1 at=255 now=0",
                     ovf_n, ovf_at, load_ovf);
        end
        push_prog(64'h5_0000, 256, 0);
        start_run(0);
        wait_idle(c);
        total++;
        if (c != 257 || sb.size() != 0) begin
            bad++;
            $display("FAIL t5_run: got cycles=%0d left=%0d, required cycles=257 left=0", c, sb.size());
        end
    endtask

    task automatic test_async_reset();
        int c;
        load_prog(64'h6000, 2, 1);
        load_prog(64'h7000, 2, 1);
        total++;
        if (load_full !== 1'b1) begin
            bad++;
            $display("FAIL t6_full: got load_full=%b, required 1", load_full);
        end
        push_prog(64'h6000, 2, 5);
        start_run(5);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({inst_out_v, inst_out_last, busy, load_full, load_ovf} !== 5'b0 || inst_out !== 64'h0) begin
            bad++;
            $display("FAIL t6_async: got v=%b last=%b busy=%b full=%b ovf=%b data=%h, required all 0",
                     inst_out_v, inst_out_last, busy, load_full, load_ovf, inst_out);
        end
        sb.delete();
        step();
        rst_n = 1'b1;
        start_run(0);
        step();
        total++;
        if (busy !== 1'b0 || inst_out_v !== 1'b0) begin
            bad++;
            $display("FAIL t6_after: got busy=%b v=%b, required 0 0", busy, inst_out_v);
        end
        load_prog(64'h8000, 2, 1);
        push_prog(64'h8000, 2, 0);
        start_run(0);
        wait_idle(c);
        total++;
        if (c != 3 || sb.size() != 0) begin
            bad++;
            $display("FAIL t6_reload: got cycles=%0d left=%0d, required cycles=3 left=0", c, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loop();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
